usb_tx_sched: RTL and testbench
===============================

// Module: usb_tx_sched
// PURPOSE
//  Sequences the TX buffer toward usb_slavefifo in the usb_clk domain. Allocates TX buffer
//  banks to the producer (cmd_decode side), queues filled banks in FIFO order and issues
//  one tx_sop per packet. Gives handshake bank 0 priority and frees each bank after the
//  slave FIFO reports completion. Replaces ad-hoc baddr increment logic with an explicit
//  alloc/queue/free scheme plus a completion timeout.
// PARAMETERS
//  BADDR_NBIT   3     bank address width; bank 0 = handshake, banks 1..2^BADDR_NBIT-1 = data
//  PKT_TIMEOUT  4096  cycles to wait in WAIT_DONE for tx_done before dropping the packet
// PORTS
//  usb_clk          in   1           sole clock (inverted IFCLK domain)
//  rst              in   1           asynchronous reset, active-high
//  fill_req         in   1           level; producer wants a free data bank
//  fill_grant       out  1           1-cycle pulse; fill_baddr valid this cycle
//  fill_baddr       out  BADDR_NBIT  granted bank (never 0)
//  fill_done        in   1           pulse; bank fill_done_baddr fully written
//  fill_done_baddr  in   BADDR_NBIT  bank being released to the TX queue
//  hs_req           in   1           pulse; handshake packet ready in bank 0
//  usb_full         in   1           EP6 full (active-high)
//  tx_sop           out  1           1-cycle pulse to usb_slavefifo.tx_cache_sop
//  tx_baddr         out  BADDR_NBIT  bank being sent; upper bits of TX buffer read address
//  tx_done          in   1           pulse from slave FIFO: packet fully written to PHY
//  pending          out  BADDR_NBIT+1  number of data banks queued (excludes in-flight)
//  busy             out  1           high in ISSUE/WAIT_DONE
//  err_timeout      out  1           1-cycle pulse when PKT_TIMEOUT expires
//  err_badbank      out  1           1-cycle pulse on fill_done for bank 0 or an unallocated bank
// BEHAVIOUR
//  Reset: all outputs 0. Free map = banks 1..2^N-1. Queue empty. hs_pend=0. State IDLE.
//   Reset mid-packet discards all banks; no tx_sop follows.
//  Allocation: when fill_req=1, a free bank exists and fill_grant was 0 last cycle, grant the
//   lowest free index (registered): fill_grant=1 for one cycle and mark the bank allocated.
//   Producer drops fill_req after seeing the grant. With no free bank, wait (no grant).
//  fill_done: valid allocated bank -> push it on the queue (depth 2^N-1, cannot overflow).
//   Bank 0 or an unallocated bank -> ignored and err_badbank pulsed.
//  hs_req sets hs_pend. A repeat hs_req while pending is merged.
//  FSM IDLE -> ISSUE: if hs_pend, select bank 0 and ignore usb_full. Otherwise, if the queue
//   is non-empty and usb_full=0, pop the head. No candidate -> stay in IDLE.
//  FSM ISSUE: tx_sop=1 for exactly this cycle -> WAIT_DONE. Timeout counter cleared.
//  FSM WAIT_DONE: on tx_done, free the bank (bank 0: clear hs_pend) -> IDLE. If the counter
//   reaches PKT_TIMEOUT-1 first: pulse err_timeout, free the bank the same way -> IDLE.
//  tx_baddr: loaded on IDLE->ISSUE and held until the next issue.
//  Latency: fill_done sampled at edge E0 -> tx_sop high in the cycle after edge E1, provided
//   IDLE, queue empty and usb_full=0. Minimum packet spacing = 3 cycles (IDLE, ISSUE, done).
//  Simultaneous events:
//   - Bank freed in the same cycle as fill_req: the freed bank is grantable next cycle only.
//   - fill_done and pop in the same cycle: push and pop both take effect; pending stays correct.
//   - tx_done outside WAIT_DONE: ignored.
//  pending and busy are registered. Pointers and counts wrap modulo the queue depth.
// TESTING
//  1 Reset; fill_req held for 3 grants -> fill_baddr 1,2,3; each grant is a 1-cycle pulse
//    with one idle cycle between grants.
//  2 fill_done bank 2 then bank 1, usb_full=0, tx_done 10 cycles after each sop
//    -> tx_sop with tx_baddr 2 then 1; both banks free again; pending returns to 0.
//  3 Queue holds bank 3 and usb_full=1 when hs_req pulses -> tx_sop with tx_baddr=0 despite
//    full; bank 3 is issued only after tx_done and usb_full=0.
//  4 All 7 banks allocated; fill_req held -> no grant. tx_done frees bank 5 -> grant 5
//    on the 2nd cycle after tx_done.
//  5 Issue bank 4 and withhold tx_done -> err_timeout at sop+PKT_TIMEOUT; bank 4 free;
//    FSM in IDLE. fill_done with bank 0 -> err_badbank pulse; queue unchanged.
//  6 Assert rst during WAIT_DONE with 3 banks queued -> outputs 0, pending=0, no later
//    tx_sop; next fill_req is granted bank 1.

Source files
------------

// File: rtl/usb_tx_sched.sv
// usb_tx_sched: TX buffer bank allocator, FIFO queue of filled banks and packet sequencer
// toward usb_slavefifo. Bank 0 carries handshakes and always wins arbitration.
module usb_tx_sched #(
  parameter int BADDR_NBIT  = 3,
  parameter int PKT_TIMEOUT = 4096
) (
  input  logic                  usb_clk,
  input  logic                  rst,
  input  logic                  fill_req,
  output logic                  fill_grant,
  output logic [BADDR_NBIT-1:0] fill_baddr,
  input  logic                  fill_done,
  input  logic [BADDR_NBIT-1:0] fill_done_baddr,
  input  logic                  hs_req,
  input  logic                  usb_full,
  output logic                  tx_sop,
  output logic [BADDR_NBIT-1:0] tx_baddr,
  input  logic                  tx_done,
  output logic [BADDR_NBIT:0]   pending,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  err_badbank
);

  localparam int NBANK = 1 << BADDR_NBIT;
  localparam int DEPTH = NBANK - 1;
  localparam int CW    = (PKT_TIMEOUT > 1) ? $clog2(PKT_TIMEOUT) : 1;
  localparam logic [NBANK-1:0] FREE_INIT = {{DEPTH{1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t                  state, state_n;
  logic [NBANK-1:0]        free_map, alloc_map;
  logic [BADDR_NBIT-1:0]   q_mem [NBANK];
  logic [BADDR_NBIT-1:0]   head, tail;
  logic [BADDR_NBIT:0]     count;
  logic                    hs_pend;
  logic [CW-1:0]           cnt;
  logic                    have_free;
  logic [BADDR_NBIT-1:0]   free_idx;
  logic                    grant_now, push, bad_bank;
  logic                    pop, issue_hs, release_bank;

  function automatic logic [BADDR_NBIT-1:0] ptr_inc(input logic [BADDR_NBIT-1:0] p);
    return (p == BADDR_NBIT'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lowest-index free data bank; descending scan leaves the smallest index last.
  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    for (int i = NBANK - 1; i >= 1; i--) begin
      if (free_map[i]) begin
        have_free = 1'b1;
        free_idx  = BADDR_NBIT'(i);
      end
    end
  end

  assign grant_now = fill_req & have_free & ~fill_grant;
  assign push      = fill_done & (fill_done_baddr != '0) & alloc_map[fill_done_baddr];
  assign bad_bank  = fill_done & ~push;
  assign pending   = count;
  assign busy      = (state != IDLE);

  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n      = state;
    pop          = 1'b0;
    issue_hs     = 1'b0;
    tx_sop       = 1'b0;
    err_timeout  = 1'b0;
    release_bank = 1'b0;
    case (state)
      IDLE: begin
        if (hs_pend) begin
          issue_hs = 1'b1;
          state_n  = ISSUE;
        end else if ((count != '0) && !usb_full) begin
          pop     = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        tx_sop  = 1'b1;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          release_bank = 1'b1;
          state_n      = IDLE;
        end else if (cnt == CW'(PKT_TIMEOUT - 1)) begin
          err_timeout  = 1'b1;
          release_bank = 1'b1;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant, push and release always touch distinct banks, so their map updates never collide.
  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      free_map    <= FREE_INIT;
      alloc_map   <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      hs_pend     <= 1'b0;
      cnt         <= '0;
      fill_grant  <= 1'b0;
      fill_baddr  <= '0;
      tx_baddr    <= '0;
      err_badbank <= 1'b0;
    end else begin
      fill_grant  <= grant_now;
      err_badbank <= bad_bank;
      if (grant_now) begin
        fill_baddr          <= free_idx;
        free_map[free_idx]  <= 1'b0;
        alloc_map[free_idx] <= 1'b1;
      end
      if (push) begin
        alloc_map[fill_done_baddr] <= 1'b0;
        tail                       <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      count <= count + (BADDR_NBIT+1)'(push) - (BADDR_NBIT+1)'(pop);
      if (release_bank && (tx_baddr != '0)) free_map[tx_baddr] <= 1'b1;
      hs_pend <= (hs_pend & ~(release_bank & (tx_baddr == '0))) | hs_req;
      if (issue_hs)  tx_baddr <= '0;
      else if (pop)  tx_baddr <= q_mem[head];
      if (state == ISSUE)          cnt <= '0;
      else if (state == WAIT_DONE) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge usb_clk) begin
    if (push) q_mem[tail] <= fill_done_baddr;
  end

endmodule

// File: tb/tb_usb_tx_sched.sv
// tb_usb_tx_sched: directed scenarios plus a randomized run against a queue-based model
// of bank ownership and packet issue.
module tb_usb_tx_sched;

  localparam int T = 4096;

  logic       usb_clk = 1'b0;
  logic       rst, fill_req, fill_done, hs_req, usb_full, tx_done;
  logic [2:0] fill_done_baddr;
  logic       fill_grant, tx_sop, busy, err_timeout, err_badbank;
  logic [2:0] fill_baddr, tx_baddr;
  logic [3:0] pending;

  int compared = 0;
  int mismatched = 0;

  usb_tx_sched #(.BADDR_NBIT(3), .PKT_TIMEOUT(T)) dut (
    .usb_clk(usb_clk), .rst(rst), .fill_req(fill_req), .fill_grant(fill_grant),
    .fill_baddr(fill_baddr), .fill_done(fill_done), .fill_done_baddr(fill_done_baddr),
    .hs_req(hs_req), .usb_full(usb_full), .tx_sop(tx_sop), .tx_baddr(tx_baddr),
    .tx_done(tx_done), .pending(pending), .busy(busy), .err_timeout(err_timeout),
    .err_badbank(err_badbank)
  );

  always #5 usb_clk = ~usb_clk;

  // Model of bank ownership: free pool, producer-held banks, FIFO of filled banks,
  // and the single packet in flight (phase 0 none, 1 sop cycle, 2 awaiting completion).
  bit m_free[8], m_alloc[8], m_hs, m_grant, m_bad;
  int m_q[$];
  int m_phase, m_bank, m_wait, m_gbank;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_free[i] = (i != 0); m_alloc[i] = 0; end
    m_q.delete();
    m_hs = 0; m_grant = 0; m_bad = 0; m_phase = 0; m_bank = 0; m_wait = 0; m_gbank = 0;
  endtask

  task automatic model_step();
    int  lowest;
    bit  ng, rel, valid;
    lowest = 0;
    for (int i = 1; i < 8; i++) if (m_free[i] && lowest == 0) lowest = i;
    ng  = fill_req && (lowest != 0) && !m_grant;
    rel = 0;
    if (m_phase == 2) begin
      if (tx_done || m_wait == T - 1) rel = 1;
      else m_wait++;
    end
    if (m_phase == 0) begin
      if (m_hs) begin m_bank = 0; m_phase = 1; end
      else if (m_q.size() > 0 && !usb_full) begin m_bank = m_q.pop_front(); m_phase = 1; end
    end else if (m_phase == 1) begin
      m_phase = 2; m_wait = 0;
    end else if (rel) begin
      m_phase = 0;
    end
    valid = (fill_done_baddr != 0) && m_alloc[fill_done_baddr];
    if (fill_done && valid) begin m_q.push_back(int'(fill_done_baddr)); m_alloc[fill_done_baddr] = 0; end
    m_bad = fill_done && !valid;
    if (rel && m_bank != 0) m_free[m_bank] = 1;
    m_hs = (m_hs && !(rel && m_bank == 0)) || hs_req;
    if (ng) begin m_free[lowest] = 0; m_alloc[lowest] = 1; m_gbank = lowest; end
    m_grant = ng;
  endtask

  task automatic clear_inputs();
    fill_req = 0; fill_done = 0; fill_done_baddr = 0; hs_req = 0; usb_full = 0; tx_done = 0;
  endtask

  task automatic do_reset();
    rst = 1; clear_inputs();
    repeat (2) @(negedge usb_clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    @(negedge usb_clk); #1;
    compared += 8;
    if (fill_grant !== 1'b0)  begin mismatched++; $display("[TB] FAIL reset_fill_grant: got %0d, expected 0", fill_grant); end
    if (fill_baddr !== 3'd0)  begin mismatched++; $display("[TB] FAIL reset_fill_baddr: got %0d, expected 0", fill_baddr); end
    if (tx_sop !== 1'b0)      begin mismatched++; $display("[TB] FAIL reset_tx_sop: got %0d, expected 0", tx_sop); end
    if (tx_baddr !== 3'd0)    begin mismatched++; $display("[TB] FAIL reset_tx_baddr: got %0d, expected 0", tx_baddr); end
    if (pending !== 4'd0)     begin mismatched++; $display("[TB] FAIL reset_pending: got %0d, expected 0", pending); end
    if (busy !== 1'b0)        begin mismatched++; $display("[TB] FAIL reset_busy: got %0d, expected 0", busy); end
    if (err_timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err_timeout: got %0d, expected 0", err_timeout); end
    if (err_badbank !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err_badbank: got %0d, expected 0", err_badbank); end
    @(negedge usb_clk);
    rst = 0;
  endtask

  task automatic test_alloc();
    bit eg;
    do_reset();
    fill_req = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge usb_clk);
      if (k == 5) fill_req = 0;
      #1;
      eg = (k % 2 == 1) && (k <= 5);
      compared++;
      if (fill_grant !== eg) begin mismatched++; $display("[TB] FAIL alloc_grant c%0d: got %0d, expected %0d", k, fill_grant, eg); end
      if (eg) begin
        compared++;
        if (fill_baddr !== 3'((k + 1) / 2)) begin mismatched++; $display("[TB] FAIL alloc_baddr c%0d: got %0d, expected %0d", k, fill_baddr, (k + 1) / 2); end
      end
    end
  endtask

  task automatic test_fifo_order();
    int sc[$], sb[$];
    int last = -100;
    bit eg;
    for (int c = 0; c <= 32; c++) begin
      @(negedge usb_clk);
      fill_done = (c <= 1); fill_done_baddr = (c == 0) ? 3'd2 : 3'd1;
      tx_done = (c == last + 10);
      #1;
      if (tx_sop) begin sc.push_back(c); sb.push_back(int'(tx_baddr)); last = c; end
      if (c == 5) begin
        compared++;
        if (pending !== 4'd1) begin mismatched++; $display("[TB] FAIL fifo_pending_mid: got %0d, expected 1", pending); end
      end
    end
    tx_done = 0;
    compared++;
    if (sc.size() != 2) begin mismatched++; $display("[TB] FAIL fifo_sop_count: got %0d, expected 2", sc.size()); end
    else begin
      compared += 4;
      if (sc[0] != 2)  begin mismatched++; $display("[TB] FAIL fifo_latency: got cycle %0d, expected 2", sc[0]); end
      if (sb[0] != 2)  begin mismatched++; $display("[TB] FAIL fifo_first_bank: got %0d, expected 2", sb[0]); end
      if (sc[1] != 14) begin mismatched++; $display("[TB] FAIL fifo_second_cycle: got %0d, expected 14", sc[1]); end
      if (sb[1] != 1)  begin mismatched++; $display("[TB] FAIL fifo_second_bank: got %0d, expected 1", sb[1]); end
    end
    compared += 2;
    if (pending !== 4'd0) begin mismatched++; $display("[TB] FAIL fifo_pending_end: got %0d, expected 0", pending); end
    if (busy !== 1'b0)    begin mismatched++; $display("[TB] FAIL fifo_busy_end: got %0d, expected 0", busy); end
    fill_req = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge usb_clk);
      if (k == 3) fill_req = 0;
      #1;
      eg = (k == 1) || (k == 3);
      compared++;
      if (fill_grant !== eg) begin mismatched++; $display("[TB] FAIL fifo_regrant c%0d: got %0d, expected %0d", k, fill_grant, eg); end
      if (eg) begin
        compared++;
        if (fill_baddr !== 3'((k + 1) / 2)) begin mismatched++; $display("[TB] FAIL fifo_regrant_bank c%0d: got %0d, expected %0d", k, fill_baddr, (k + 1) / 2); end
      end
    end
  endtask

  task automatic test_hs_priority();
    int sc[$], sb[$];
    for (int c = 0; c <= 26; c++) begin
      @(negedge usb_clk);
      fill_done = (c == 0); fill_done_baddr = 3'd3;
      usb_full = (c < 15); hs_req = (c == 2); tx_done = (c == 8) || (c == 20);
      #1;
      if (tx_sop) begin sc.push_back(c); sb.push_back(int'(tx_baddr)); end
      if (c == 10) begin
        compared++;
        if (pending !== 4'd1) begin mismatched++; $display("[TB] FAIL hs_pending_held: got %0d, expected 1", pending); end
      end
      if (c == 22) begin
        compared++;
        if (pending !== 4'd0) begin mismatched++; $display("[TB] FAIL hs_pending_end: got %0d, expected 0", pending); end
      end
    end
    clear_inputs();
    compared++;
    if (sc.size() != 2) begin mismatched++; $display("[TB] FAIL hs_sop_count: got %0d, expected 2", sc.size()); end
    else begin
      compared += 4;
      if (sc[0] != 4)  begin mismatched++; $display("[TB] FAIL hs_first_cycle: got %0d, expected 4", sc[0]); end
      if (sb[0] != 0)  begin mismatched++; $display("[TB] FAIL hs_first_bank: got %0d, expected 0", sb[0]); end
      if (sc[1] != 16) begin mismatched++; $display("[TB] FAIL hs_data_cycle: got %0d, expected 16", sc[1]); end
      if (sb[1] != 3)  begin mismatched++; $display("[TB] FAIL hs_data_bank: got %0d, expected 3", sb[1]); end
    end
  endtask

  task automatic test_full_alloc();
    bit eg;
    fill_req = 1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge usb_clk);
      if (c == 9) fill_req = 0;
      #1;
      eg = (c % 2 == 1);
      compared++;
      if (fill_grant !== eg) begin mismatched++; $display("[TB] FAIL full_grant c%0d: got %0d, expected %0d", c, fill_grant, eg); end
      if (eg) begin
        compared++;
        if (fill_baddr !== 3'((c + 1) / 2 + 2)) begin mismatched++; $display("[TB] FAIL full_bank c%0d: got %0d, expected %0d", c, fill_baddr, (c + 1) / 2 + 2); end
      end
    end
    for (int c = 0; c <= 12; c++) begin
      @(negedge usb_clk);
      fill_req = (c < 10); fill_done = (c == 0); fill_done_baddr = 3'd5; tx_done = (c == 8);
      #1;
      compared++;
      if (fill_grant !== (c == 10)) begin mismatched++; $display("[TB] FAIL full_wait_grant c%0d: got %0d, expected %0d", c, fill_grant, c == 10); end
      if (c == 10) begin
        compared++;
        if (fill_baddr !== 3'd5) begin mismatched++; $display("[TB] FAIL full_freed_bank: got %0d, expected 5", fill_baddr); end
      end
      if (c == 2) begin
        compared++;
        if (!(tx_sop === 1'b1 && tx_baddr === 3'd5)) begin mismatched++; $display("[TB] FAIL full_sop: got sop %0d bank %0d, expected sop 1 bank 5", tx_sop, tx_baddr); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int to_c = -1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge usb_clk);
      fill_done = (c == 0); fill_done_baddr = 3'd4;
      #1;
      if (c == 2) begin
        compared++;
        if (!(tx_sop === 1'b1 && tx_baddr === 3'd4)) begin mismatched++; $display("[TB] FAIL to_sop: got sop %0d bank %0d, expected sop 1 bank 4", tx_sop, tx_baddr); end
      end
      if (err_timeout === 1'b1) begin to_c = c; break; end
    end
    compared++;
    if (to_c != 2 + T) begin mismatched++; $display("[TB] FAIL to_cycle: got %0d, expected %0d", to_c, 2 + T); end
    @(negedge usb_clk); #1;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL to_idle: got busy %0d, expected 0", busy); end
    fill_req = 1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge usb_clk);
      if (k == 1) fill_req = 0;
      #1;
      compared++;
      if (fill_grant !== (k == 1)) begin mismatched++; $display("[TB] FAIL to_regrant c%0d: got %0d, expected %0d", k, fill_grant, k == 1); end
      if (k == 1) begin
        compared++;
        if (fill_baddr !== 3'd4) begin mismatched++; $display("[TB] FAIL to_freed_bank: got %0d, expected 4", fill_baddr); end
      end
    end
    for (int c = 0; c <= 3; c++) begin
      @(negedge usb_clk);
      fill_done = (c == 0); fill_done_baddr = 3'd0;
      #1;
      compared += 3;
      if (err_badbank !== (c == 1)) begin mismatched++; $display("[TB] FAIL badbank c%0d: got %0d, expected %0d", c, err_badbank, c == 1); end
      if (pending !== 4'd0) begin mismatched++; $display("[TB] FAIL badbank_pending c%0d: got %0d, expected 0", c, pending); end
      if (tx_sop !== 1'b0)  begin mismatched++; $display("[TB] FAIL badbank_sop c%0d: got %0d, expected 0", c, tx_sop); end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    int seq[4] = '{1, 2, 3, 6};
    for (int c = 0; c <= 8; c++) begin
      @(negedge usb_clk);
      fill_done = (c <= 3); fill_done_baddr = 3'(seq[c < 4 ? c : 0]);
      if (c == 6) rst = 1;
      if (c == 8) rst = 0;
      #1;
      if (c == 5) begin
        compared += 2;
        if (pending !== 4'd3) begin mismatched++; $display("[TB] FAIL rmid_pending: got %0d, expected 3", pending); end
        if (busy !== 1'b1)    begin mismatched++; $display("[TB] FAIL rmid_busy: got %0d, expected 1", busy); end
      end
      if (c == 6) begin
        compared++;
        if ({fill_grant, fill_baddr, tx_sop, tx_baddr, pending, busy, err_timeout, err_badbank} !== 15'd0) begin
          mismatched++;
          $display("[TB] FAIL rmid_outputs: got %0h, expected 0", {fill_grant, fill_baddr, tx_sop, tx_baddr, pending, busy, err_timeout, err_badbank});
        end
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge usb_clk); #1;
      compared++;
      if (tx_sop !== 1'b0 || pending !== 4'd0) begin mismatched++; $display("[TB] FAIL rmid_quiet c%0d: got sop %0d pending %0d, expected 0 0", c, tx_sop, pending); end
    end
    fill_req = 1;
    @(negedge usb_clk);
    fill_req = 0;
    #1;
    compared++;
    if (!(fill_grant === 1'b1 && fill_baddr === 3'd1)) begin mismatched++; $display("[TB] FAIL rmid_grant: got grant %0d bank %0d, expected 1 1", fill_grant, fill_baddr); end
  endtask

  task automatic test_random();
    int al[$];
    int bad_before;
    bad_before = mismatched;
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      al.delete();
      for (int b = 1; b < 8; b++) if (m_alloc[b]) al.push_back(b);
      fill_req  = ($urandom_range(0, 3) != 0);
      fill_done = ($urandom_range(0, 3) == 0);
      if (al.size() > 0 && $urandom_range(0, 7) != 0) fill_done_baddr = 3'(al[$urandom_range(0, al.size() - 1)]);
      else fill_done_baddr = 3'($urandom_range(0, 7));
      hs_req   = ($urandom_range(0, 19) == 0);
      usb_full = ($urandom_range(0, 2) == 0);
      tx_done  = ($urandom_range(0, 4) == 0);
      #1;
      compared += 6;
      if (fill_grant !== m_grant) begin mismatched++; $display("[TB] FAIL rnd_grant i%0d: got %0d, expected %0d", i, fill_grant, m_grant); end
      if (tx_sop !== (m_phase == 1)) begin mismatched++; $display("[TB] FAIL rnd_sop i%0d: got %0d, expected %0d", i, tx_sop, m_phase == 1); end
      if (pending !== 4'(m_q.size())) begin mismatched++; $display("[TB] FAIL rnd_pending i%0d: got %0d, expected %0d", i, pending, m_q.size()); end
      if (busy !== (m_phase != 0)) begin mismatched++; $display("[TB] FAIL rnd_busy i%0d: got %0d, expected %0d", i, busy, m_phase != 0); end
      if (err_badbank !== m_bad) begin mismatched++; $display("[TB] FAIL rnd_badbank i%0d: got %0d, expected %0d", i, err_badbank, m_bad); end
      if (err_timeout !== (m_phase == 2 && m_wait == T - 1 && !tx_done)) begin mismatched++; $display("[TB] FAIL rnd_timeout i%0d: got %0d, expected 0", i, err_timeout); end
      if (m_grant) begin
        compared++;
        if (fill_baddr !== 3'(m_gbank)) begin mismatched++; $display("[TB] FAIL rnd_grant_bank i%0d: got %0d, expected %0d", i, fill_baddr, m_gbank); end
      end
      if (m_phase == 1) begin
        compared++;
        if (tx_baddr !== 3'(m_bank)) begin mismatched++; $display("[TB] FAIL rnd_tx_bank i%0d: got %0d, expected %0d", i, tx_baddr, m_bank); end
      end
      model_step();
      if (mismatched - bad_before > 20) break;
      @(negedge usb_clk);
    end
    clear_inputs();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_alloc();
    test_fifo_order();
    test_hs_priority();
    test_full_alloc();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
